// File: rtl/muldiv_sequencer_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 op codes, sequencer states
// and the M-extension funct7 that the control unit decodes to route ops here.
package muldiv_sequencer_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Which operands are interpreted as two's complement for a given op.
    function automatic logic op_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// hi/lo hold the product (mul) or remainder/quotient-with-dividend (div).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_fits;
    logic [XLEN-1:0] div_sub;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_fits  = div_shift >= {1'b0, opnd};
        // The partial remainder stays below the divisor, so the low word of the difference is exact.
        div_sub   = div_shift[XLEN-1:0] - opnd;
        if (is_div) begin
            hi_next = div_fits ? div_sub : div_shift[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], div_fits};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Fixed-latency iterative RV32M unit: PREP, XLEN CALC iterations, FIX, then a one-cycle DONE.
// Holds the EX stage through busy; result is held until the next completed operation.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   raw_a;
    logic [XLEN-1:0]   raw_b;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic              sign_a;
    logic              sign_b;
    logic              div_zero;
    logic              ovf;

    logic              is_div;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   hi_next;
    logic [XLEN-1:0]   lo_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    assign is_div = f3_q[2];

    always_comb begin
        neg_a = op_signed_a(f3_q) & raw_a[XLEN-1];
        neg_b = op_signed_b(f3_q) & raw_b[XLEN-1];
        mag_a = neg_a ? -raw_a : raw_a;
        mag_b = neg_b ? -raw_b : raw_b;
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (is_div),
        .hi      (hi),
        .lo      (lo),
        .opnd    (opnd),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // Sign correction and result selection; special divide cases override the iterated value.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -{hi, lo} : {hi, lo};
        quo_fix  = (sign_a ^ sign_b) ? -lo : lo;
        rem_fix  = sign_a ? -hi : hi;
        fix_result = '0;
        if (!is_div) begin
            fix_result = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (!f3_q[1]) begin
            if (div_zero)
                fix_result = '1;
            else if (ovf)
                fix_result = MOST_NEG;
            else
                fix_result = quo_fix;
        end else begin
            if (div_zero)
                fix_result = raw_a;
            else if (ovf)
                fix_result = '0;
            else
                fix_result = rem_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            f3_q     <= '0;
            raw_a    <= '0;
            raw_b    <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            ready    <= 1'b1;
        end else begin
            done <= 1'b0;
            if (flush && state != ST_IDLE) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                ready <= 1'b1;
            end else begin
                case (state)
                    // Operands are captured at acceptance so the requester may drop them afterwards.
                    ST_IDLE, ST_DONE: begin
                        if (start && !flush) begin
                            f3_q  <= funct3;
                            raw_a <= op_a;
                            raw_b <= op_b;
                            state <= ST_PREP;
                            busy  <= 1'b1;
                            ready <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_PREP: begin
                        sign_a   <= neg_a;
                        sign_b   <= neg_b;
                        opnd     <= is_div ? mag_b : mag_a;
                        lo       <= is_div ? mag_a : mag_b;
                        hi       <= '0;
                        cnt      <= '0;
                        div_zero <= (raw_b == '0);
                        ovf      <= is_div && !f3_q[0] && (raw_a == MOST_NEG) && (raw_b == '1);
                        state    <= ST_CALC;
                    end
                    ST_CALC: begin
                        hi  <= hi_next;
                        lo  <= lo_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(XLEN-1))
                            state <= ST_FIX;
                    end
                    ST_FIX: begin
                        result <= fix_result;
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        ready  <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit that sits beside the main ALU in the EX stage.
- The control unit routes M-extension instructions here (funct7 = 0000001) instead of to the ALU.
- Runs a fixed-latency radix-2 shift-add / restoring-divide sequence and holds the pipeline via busy.
- Reports completion with a one-cycle done pulse and a held result.

Parameters:
XLEN, 32, operand/result width (only 32 is verified)
CNT_W, 5, iteration counter width = clog2(XLEN)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while ready=1
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value (multiplicand / dividend)
op_b  input  XLEN  rs2 value (multiplier / divisor)
flush  input  1  synchronous abort from hazard/branch logic
ready  output  1  can accept start (state IDLE or DONE)
busy  output  1  operation in flight (PREP, CALC or FIX); drives EX stall
done  output  1  one-cycle completion pulse (state DONE)
result  output  XLEN  final value; stable from DONE until the next accepted start

Behaviour:
- Reset (rst_n=0, asynchronous, any state) sets:
  - state=IDLE, counter=0, internal accumulators=0
  - result=0, done=0, busy=0, ready=1
- States and transitions:
  - IDLE: start -> PREP; otherwise stay.
  - PREP (1 cycle): latch funct3 and operands; record sign flags; convert signed operands to magnitudes (MULH: both signed; MULHSU: op_a only; DIV/REM: both). Record div-by-zero (op_b==0) and overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF). Clear counter. -> CALC.
  - CALC (XLEN cycles): one iteration per cycle.
    - Multiply: 2*XLEN-bit product register, conditional add, shift right.
    - Divide: shift remainder left, trial subtract, set quotient bit.
    - Leaves at counter==XLEN-1 -> FIX.
  - FIX (1 cycle): apply sign correction, then select the result.
    - MUL: low word. MULH/MULHSU/MULHU: high word.
    - DIV/DIVU: quotient. REM/REMU: remainder.
    - Quotient sign = sign_a XOR sign_b; remainder sign = sign of dividend.
    - Div-by-zero: quotient=all ones; remainder=op_a (unmodified).
    - Overflow: quotient=0x80000000; remainder=0.
    - -> DONE.
  - DONE (1 cycle): done=1. start -> PREP (back-to-back, new operands latched next cycle); else -> IDLE.
- Latency is fixed and data-independent:
  - start in cycle 0 -> done in cycle XLEN+3 (cycle 35 for XLEN=32).
  - Special cases do not shorten it.
- Handshake:
  - start is ignored while busy=1; operands need only be valid in the cycle start is accepted.
  - The requester must hold funct3/op_a/op_b stable in the accept cycle only.
- result updates only on the FIX->DONE edge. It holds that value through IDLE and through any later PREP/CALC/FIX until the next FIX.
- flush:
  - Any state except IDLE -> IDLE on the next edge; no done pulse; result unchanged.
  - flush dominates a same-cycle start (start dropped).
  - flush in IDLE is a no-op.
- busy and done are never simultaneously 1; ready = ~busy.
- Counter wraps never observed: it is cleared in PREP and compared at XLEN-1.

Decomposition:
- Shared include (muldiv_defs):
  - funct3 localparams for the 8 RV32M ops
  - state encoding (IDLE, PREP, CALC, FIX, DONE; 3-bit)
  - M-extension funct7 constant 7'b0000001, for use by the control unit too
- One natural sub-module, muldiv_step: combinational single-iteration datapath (add/shift for mul, trial-subtract/shift for div). Instantiated once inside the sequencer's CALC path.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD -> busy cycles 1-34, done only in cycle 35, result=0xFFFFFFEB. MULH 0x80000000*0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- Corner cases: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. Each with done still at cycle 35.
- flush asserted in cycle 10 -> busy=0 and ready=1 in cycle 11, no done, result keeps prior value. New start in cycle 12 -> done in cycle 47. Start during busy is ignored.
- Back-to-back: start held high in the DONE cycle -> second op done 35 cycles later. rst_n pulsed low mid-CALC -> outputs return to reset values immediately (asynchronous), no done afterwards.
